// File: rtl/audio_pio_master.sv
// ---------------------------------------------------------------------------
// audio_pio_master
//
// Moves one audio sample per sample_tick through an Avalon-MM PIO.
// Each transaction:
//   1. takes a sample from the sink stream,
//   2. writes it to the PIO output register,
//   3. waits READ_LATENCY+1 cycles,
//   4. reads the PIO input port back,
//   5. offers the read value on the source stream.
// A tick that finds no sink sample skips the write but still does the read.
// A tick that arrives while a transaction is in flight is dropped.
// Both kinds of lost tick are counted.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   i_sample_tick       one-cycle pulse that starts a transaction
//   i_snk_data/valid    sample stream in
//   o_snk_ready         sample stream in
//   o_src_data/valid    read-back stream out
//   i_src_ready         read-back stream out
//   o_avm_*             Avalon-MM master towards the PIO (address fixed at 0)
//   i_avm_readdata      Avalon-MM master towards the PIO; only [15:0] is used
//   o_busy              high while a transaction is in flight
//   o_underrun_cnt      saturating count of ticks with no sample available
//   o_overrun_cnt       saturating count of ticks dropped while busy
//   i_clr_stats         synchronous clear of both counters
//
// READ_LATENCY must lie in 1..7 so that it fits the 3-bit wait counter.
// ---------------------------------------------------------------------------
module audio_pio_master #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_sample_tick,
  input  logic [15:0] i_snk_data,
  input  logic        i_snk_valid,
  output logic        o_snk_ready,
  output logic [15:0] o_src_data,
  output logic        o_src_valid,
  input  logic        i_src_ready,
  output logic [1:0]  o_avm_address,
  output logic        o_avm_chipselect,
  output logic        o_avm_write_n,
  output logic [31:0] o_avm_writedata,
  input  logic [31:0] i_avm_readdata,
  output logic        o_busy,
  output logic [7:0]  o_underrun_cnt,
  output logic [7:0]  o_overrun_cnt,
  input  logic        i_clr_stats
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    RDWAIT = 2'd2,
    PUSH   = 2'd3
  } state_t;

  localparam logic [2:0] LP_RD_LOAD = 3'(READ_LATENCY);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_sample;
  logic [15:0] r_src_data;
  logic [2:0]  r_rd_cnt;
  logic [7:0]  r_underrun;
  logic [7:0]  r_overrun;

  logic w_accept;
  logic w_underrun_ev;
  logic w_overrun_ev;
  logic w_rd_done;
  logic w_unused_rd_hi;

  assign w_accept      = (r_state == IDLE) && i_sample_tick && i_snk_valid;
  assign w_underrun_ev = (r_state == IDLE) && i_sample_tick && !i_snk_valid;
  // Any tick outside IDLE is lost, including the PUSH completion cycle.
  assign w_overrun_ev  = (r_state != IDLE) && i_sample_tick;
  assign w_rd_done     = (r_state == RDWAIT) && (r_rd_cnt == 3'd0);

  // The PIO input port is 16 bits wide, so the upper readdata half carries nothing.
  assign w_unused_rd_hi = ^i_avm_readdata[31:16];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (i_sample_tick) begin
          w_next_state = i_snk_valid ? WRITE : RDWAIT;
        end
      end
      WRITE:  w_next_state = RDWAIT;
      RDWAIT: begin
        if (r_rd_cnt == 3'd0) begin
          w_next_state = PUSH;
        end
      end
      PUSH: begin
        if (i_src_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // The wait counter is loaded on the transition into RDWAIT.
  // It then counts down to 0, so RDWAIT spans READ_LATENCY+1 cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sample   <= 16'h0;
      r_src_data <= 16'h0;
      r_rd_cnt   <= 3'd0;
    end else begin
      if (w_accept) begin
        r_sample <= i_snk_data;
      end
      if ((r_state != RDWAIT) && (w_next_state == RDWAIT)) begin
        r_rd_cnt <= LP_RD_LOAD;
      end else if ((r_state == RDWAIT) && (r_rd_cnt != 3'd0)) begin
        r_rd_cnt <= r_rd_cnt - 3'd1;
      end
      if (w_rd_done) begin
        r_src_data <= i_avm_readdata[15:0];
      end
    end
  end

  // A clear takes priority over a coincident increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_underrun <= 8'h0;
      r_overrun  <= 8'h0;
    end else if (i_clr_stats) begin
      r_underrun <= 8'h0;
      r_overrun  <= 8'h0;
    end else begin
      if (w_underrun_ev && (r_underrun != 8'hFF)) begin
        r_underrun <= r_underrun + 8'd1;
      end
      if (w_overrun_ev && (r_overrun != 8'hFF)) begin
        r_overrun <= r_overrun + 8'd1;
      end
    end
  end

  // snk_ready is combinational in the tick cycle.
  // It is gated by reset_n so that it drops immediately while reset is held.
  assign o_snk_ready      = reset_n && w_accept;
  assign o_src_data       = r_src_data;
  assign o_src_valid      = (r_state == PUSH);
  assign o_avm_address    = 2'b00;
  assign o_avm_chipselect = (r_state == WRITE);
  assign o_avm_write_n    = (r_state != WRITE);
  assign o_avm_writedata  = {16'h0, r_sample};
  assign o_busy           = (r_state != IDLE);
  assign o_underrun_cnt   = r_underrun;
  assign o_overrun_cnt    = r_overrun;

endmodule
